// File: rtl/ucsbece154b_mem_arbiter.sv
// ucsbece154b_mem_arbiter
//   Shares one single-ported memory between the fetch stage (read-only) and the memory stage
//   (load/store). One transaction is outstanding at a time. The data side normally wins, but
//   fetch is forced through after MAX_D_STREAK consecutive data grants made while it waited.
//   A fetch flush drops the response of an in-flight fetch; data transactions are never dropped.
// Ports
//   clk, reset                       clock (rising edge) and async active-low reset
//   if_req_i/if_addr_i/if_flush_i    fetch request, address, redirect
//   if_valid_o/if_rdata_o/if_busy_o  fetch response pulse, data, stall source
//   d_req_i/d_we_i/d_addr_i/d_wdata_i data request, store enable, address, store data
//   d_valid_o/d_rdata_o/d_busy_o     data response pulse, load data, stall source
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  registered request towards memory
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i         memory accept, response, read data
//   conflict_cnt_o                   saturating count of idle cycles with both requests high
module ucsbece154b_mem_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned MAX_D_STREAK = 4,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              if_flush_i,
   output logic              if_valid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_busy_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_valid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_busy_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [CNT_W-1:0]  conflict_cnt_o
);

   localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

   typedef enum logic [2:0] {StIdle, StIReq, StIWait, StDReq, StDWait} state_t;

   state_t              state, nextState;
   logic [STREAK_W-1:0] dStreak;
   logic                drop;
   logic                dWins;

   // Data wins unless fetch has already been passed over MAX_D_STREAK times in a row.
   assign dWins = d_req_i & (~if_req_i | (dStreak < STREAK_W'(MAX_D_STREAK)));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= StIdle;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      unique case (state)
         StIdle: begin
            if (dWins) begin
               nextState = StDReq;
            end else if (if_req_i) begin
               nextState = StIReq;
            end
         end
         StIReq:  if (mem_gnt_i)    nextState = StIWait;
         StDReq:  if (mem_gnt_i)    nextState = StDWait;
         StIWait: if (mem_rvalid_i) nextState = StIdle;
         StDWait: if (mem_rvalid_i) nextState = StIdle;
         default: nextState = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      mem_req_o  = (state == StIReq) | (state == StDReq);
      // A flush in the response cycle itself also suppresses the pulse.
      if_valid_o = (state == StIWait) & mem_rvalid_i & ~drop & ~if_flush_i;
      d_valid_o  = (state == StDWait) & mem_rvalid_i;
      if_busy_o  = if_req_i & ~if_valid_o;
      d_busy_o   = d_req_i & ~d_valid_o;
      if_rdata_o = mem_rdata_i;
      d_rdata_o  = mem_rdata_i;
   end

   // Request registers, streak, drop flag and conflict counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_we_o       <= 1'b0;
         mem_addr_o     <= '0;
         mem_wdata_o    <= '0;
         dStreak        <= '0;
         drop           <= 1'b0;
         conflict_cnt_o <= '0;
      end else begin
         if (state == StIdle) begin
            if (dWins) begin
               mem_we_o    <= d_we_i;
               mem_addr_o  <= d_addr_i;
               mem_wdata_o <= d_wdata_i;
            end else if (if_req_i) begin
               mem_we_o    <= 1'b0;
               mem_addr_o  <= if_addr_i;
               mem_wdata_o <= '0;
            end
            // Only data grants made while fetch waits extend the streak; anything else resets it.
            if (if_req_i && dWins) begin
               dStreak <= dStreak + 1'b1;
            end else begin
               dStreak <= '0;
            end
            if (if_req_i && d_req_i && !(&conflict_cnt_o)) begin
               conflict_cnt_o <= conflict_cnt_o + 1'b1;
            end
         end
         if (state == StIWait && mem_rvalid_i) begin
            drop <= 1'b0;
         end else if ((state == StIReq || state == StIWait) && if_flush_i) begin
            drop <= 1'b1;
         end
      end
   end

endmodule
